// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side (I fetch, D load/store) and memory-side signals for mem_port_arbiter.
// slave = arbiter view, master = environment (requesters plus memory) view.
interface mem_port_arbiter_if #(
    parameter int N = 32
);
    logic         if_req;
    logic [N-1:0] if_addr;
    logic         if_gnt;
    logic         if_rvalid;
    logic [N-1:0] if_rdata;

    logic         d_req;
    logic         d_we;
    logic [N-1:0] d_addr;
    logic [N-1:0] d_wdata;
    logic         d_gnt;
    logic         d_rvalid;
    logic [N-1:0] d_rdata;

    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [N-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D), one transaction outstanding.
// Optional fetch starvation guard is built when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_port_arbiter #(
    parameter int N            = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_e;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_e;

    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    state_e       state_q, state_d;
    owner_e       owner_q, owner_d;
    logic         if_gnt_q, if_gnt_d;
    logic         d_gnt_q, d_gnt_d;
    logic         if_rvalid_q, if_rvalid_d;
    logic         d_rvalid_q, d_rvalid_d;
    logic [N-1:0] if_rdata_q, if_rdata_d;
    logic [N-1:0] d_rdata_q, d_rdata_d;
    logic         mem_req_q, mem_req_d;
    logic         mem_we_q, mem_we_d;
    logic [N-1:0] mem_addr_q, mem_addr_d;
    logic [N-1:0] mem_wdata_q, mem_wdata_d;

    logic grant_i_s;
    logic grant_d_s;
    logic force_i_s;
    logic complete_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    assign force_i_s = (starve_cnt_q == CW'(STARVE_LIMIT));

    // Count D grants taken while fetch was waiting; reset once fetch is served or idle.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if ((state_q == ST_IDLE) && !bus.if_req) begin
            starve_cnt_d = '0;
        end else if ((state_q == ST_IDLE) && grant_i_s) begin
            starve_cnt_d = '0;
        end else if ((state_q == ST_IDLE) && grant_d_s && !force_i_s) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_i_s = 1'b0;
`endif

    // D is the older instruction and wins, unless fetch has waited too long.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (bus.d_req && !(bus.if_req && force_i_s)) begin
            grant_d_s = 1'b1;
        end else if (bus.if_req) begin
            grant_i_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // A response only counts once the memory has accepted the request.
    assign complete_s = bus.mem_rvalid &&
                        ((state_q == ST_WAIT) || ((state_q == ST_ISSUE) && bus.mem_gnt));

    // Transaction FSM: latch the winner, hold the memory request, wait for the response.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d_s) begin
                    state_d     = ST_ISSUE;
                    owner_d     = OWN_D;
                    d_gnt_d     = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                end else if (grant_i_s) begin
                    state_d     = ST_ISSUE;
                    owner_d     = OWN_I;
                    if_gnt_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_gnt && bus.mem_rvalid) begin
                    state_d   = ST_IDLE;
                    owner_d   = OWN_NONE;
                    mem_req_d = 1'b0;
                end else if (bus.mem_gnt) begin
                    state_d   = ST_WAIT;
                    mem_req_d = 1'b0;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                owner_d   = OWN_NONE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Route the completing response to the requester that owns the transaction.
    always_comb begin
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if (complete_s && (owner_q == OWN_I)) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
        end else if (complete_s && (owner_q == OWN_D)) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_we_q ? '0 : bus.mem_rdata;
        end else begin
            if_rvalid_d = 1'b0;
            d_rvalid_d  = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected grants, memory
// accesses and responses; negedge monitors pop and compare whenever the DUT presents them.
module tb_mem_port_arbiter;
    typedef struct { logic is_i; logic [31:0] data; } rsp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mtx_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   cyc;
    int   rv_count;
    int   last_d_gnt_cyc, last_i_gnt_cyc, last_d_rv_cyc, last_i_rv_cyc;
    int   lat, gnt_wait;
    bit   spurious;

    rsp_t        exp_rsp[$];
    logic        exp_gnt[$];
    mtx_t        exp_mem[$];
    logic [31:0] mem_arr [logic [31:0]];

    mem_port_arbiter_if #(.N(32)) bus ();

    mem_port_arbiter #(.N(32), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_txn(input logic is_i, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata);
        mtx_t m;
        rsp_t r;
        m.we = we; m.addr = addr; m.wdata = wdata;
        r.is_i = is_i; r.data = rdata;
        exp_gnt.push_back(is_i);
        exp_mem.push_back(m);
        exp_rsp.push_back(r);
    endtask

    // Grant and response monitor.
    always @(negedge clk) begin : mon
        rsp_t r;
        logic g;
        if (rst_n) begin
            if (bus.d_gnt) begin
                last_d_gnt_cyc = cyc;
                if (exp_gnt.size() == 0) check("unexpected_d_gnt", 32'd1, 32'd0);
                else begin g = exp_gnt.pop_front(); check("gnt_is_i", 32'd0, 32'(g)); end
            end
            if (bus.if_gnt) begin
                last_i_gnt_cyc = cyc;
                if (exp_gnt.size() == 0) check("unexpected_if_gnt", 32'd1, 32'd0);
                else begin g = exp_gnt.pop_front(); check("gnt_is_i", 32'd1, 32'(g)); end
            end
            if (bus.d_rvalid) begin
                rv_count++;
                last_d_rv_cyc = cyc;
                if (exp_rsp.size() == 0) check("unexpected_d_rvalid", 32'd1, 32'd0);
                else begin
                    r = exp_rsp.pop_front();
                    check("rsp_is_i", 32'd0, 32'(r.is_i));
                    check("d_rdata", bus.d_rdata, r.data);
                end
            end
            if (bus.if_rvalid) begin
                rv_count++;
                last_i_rv_cyc = cyc;
                if (exp_rsp.size() == 0) check("unexpected_if_rvalid", 32'd1, 32'd0);
                else begin
                    r = exp_rsp.pop_front();
                    check("rsp_is_i", 32'd1, 32'(r.is_i));
                    check("if_rdata", bus.if_rdata, r.data);
                end
            end
        end
    end

    // Memory model: optional grant delay, response latency, checks each accepted access.
    initial begin : memory
        int   cnt;
        int   gw;
        bit   busy;
        logic [31:0] resp;
        mtx_t m;
        busy = 1'b0; cnt = 0; gw = 0; resp = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h5A5A_5A5A;
        forever begin
            @(negedge clk);
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h5A5A_5A5A;
            if (!rst_n) begin
                busy = 1'b0; cnt = 0; gw = 0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin busy = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = resp; end
            end else if (bus.mem_req) begin
                if (gw < gnt_wait) gw++;
                else begin
                    gw = 0;
                    bus.mem_gnt = 1'b1;
                    if (exp_mem.size() == 0) check("unexpected_mem_req", 32'd1, 32'd0);
                    else begin
                        m = exp_mem.pop_front();
                        check("mem_we", 32'(bus.mem_we), 32'(m.we));
                        check("mem_addr", bus.mem_addr, m.addr);
                        check("mem_wdata", bus.mem_wdata, m.wdata);
                    end
                    if (bus.mem_we) begin
                        mem_arr[bus.mem_addr] = bus.mem_wdata;
                        resp = 32'hFACE_FACE;
                    end else begin
                        resp = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : 32'h0;
                    end
                    if (lat == 0) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = resp; end
                    else begin busy = 1'b1; cnt = lat; end
                end
            end else if (spurious) begin
                bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hEEEE_EEEE;
            end
        end
    end

    task automatic d_request(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        do begin @(negedge clk); n++; end while (!bus.d_gnt && n < 200);
        check("d_gnt_seen", 32'(bus.d_gnt), 32'd1);
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'hBAD0_BAD0; bus.d_wdata = 32'hFFFF_FFFF;
    endtask

    task automatic i_request(input logic [31:0] addr);
        int n;
        n = 0;
        bus.if_req = 1'b1; bus.if_addr = addr;
        do begin @(negedge clk); n++; end while (!bus.if_gnt && n < 200);
        check("if_gnt_seen", 32'(bus.if_gnt), 32'd1);
        bus.if_req = 1'b0; bus.if_addr = 32'hBAD1_BAD1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || exp_gnt.size() != 0) && n < 300) begin
            @(negedge clk); n++;
        end
        check("drain_pending", 32'(exp_rsp.size() + exp_gnt.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 32'({bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid,
                                  bus.mem_req, bus.mem_we}), 32'd0);
        check({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
        check({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0;
        int rv0;
        logic [31:0] d_addr_t [5];
        logic [31:0] d_data_t [5];
        n_pass = 0; n_total = 0; cyc = 0; rv_count = 0; spurious = 1'b0;
        lat = 1; gnt_wait = 0;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Stray memory responses while idle must be ignored.
        spurious = 1'b1;
        repeat (2) @(negedge clk);
        spurious = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_rvalid_ignored", 32'(rv_count), 32'd0);

        // Single load, memory answers 2 cycles after its grant.
        lat = 2;
        mem_arr[32'h40] = 32'hDEAD_BEEF;
        expect_txn(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);
        c0 = cyc;
        d_request(1'b0, 32'h40, 32'h0);
        drain();
        check("load_gnt_cycle", 32'(last_d_gnt_cyc - c0), 32'd1);
        check("load_rvalid_cycle", 32'(last_d_rv_cyc - c0), 32'd4);

        // Collision: D first, I granted right after D completes.
        lat = 1;
        mem_arr[32'h80]  = 32'hCAFE_0080;
        mem_arr[32'h100] = 32'h1111_0100;
        expect_txn(1'b0, 1'b0, 32'h80, 32'h0, 32'hCAFE_0080);
        expect_txn(1'b1, 1'b0, 32'h100, 32'h0, 32'h1111_0100);
        fork
            d_request(1'b0, 32'h80, 32'h0);
            i_request(32'h100);
        join
        drain();
        check("i_gnt_after_d_rvalid", 32'(last_i_gnt_cyc - last_d_rv_cyc), 32'd1);

        // Zero-latency memory: skips WAIT.
        lat = 0;
        mem_arr[32'h200] = 32'h0BAD_F00D;
        expect_txn(1'b1, 1'b0, 32'h200, 32'h0, 32'h0BAD_F00D);
        c0 = cyc;
        i_request(32'h200);
        drain();
        check("zero_lat_rvalid_cycle", 32'(last_i_rv_cyc - c0), 32'd2);

        // Store with delayed memory grant (mem_* must stay latched), then read it back.
        lat = 1; gnt_wait = 2;
        expect_txn(1'b0, 1'b1, 32'h300, 32'h1234_5678, 32'h0);
        d_request(1'b1, 32'h300, 32'h1234_5678);
        drain();
        gnt_wait = 0;
        expect_txn(1'b0, 1'b0, 32'h300, 32'h0, 32'h1234_5678);
        d_request(1'b0, 32'h300, 32'h0);
        drain();

        // Starvation: both requesters held high.
        lat = 1;
        d_addr_t = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410};
        d_data_t = '{32'hD000_0400, 32'hD000_0404, 32'hD000_0408, 32'hD000_040C, 32'hD000_0410};
        for (int j = 0; j < 5; j++) mem_arr[d_addr_t[j]] = d_data_t[j];
        mem_arr[32'h500] = 32'h1500_0500;
`ifdef MEM_ARB_STARVE_GUARD_EN
        for (int j = 0; j < 4; j++) expect_txn(1'b0, 1'b0, d_addr_t[j], 32'h0, d_data_t[j]);
        expect_txn(1'b1, 1'b0, 32'h500, 32'h0, 32'h1500_0500);
        expect_txn(1'b0, 1'b0, d_addr_t[4], 32'h0, d_data_t[4]);
`else
        for (int j = 0; j < 5; j++) expect_txn(1'b0, 1'b0, d_addr_t[j], 32'h0, d_data_t[j]);
        expect_txn(1'b1, 1'b0, 32'h500, 32'h0, 32'h1500_0500);
`endif
        fork
            begin
                for (int j = 0; j < 5; j++) d_request(1'b0, d_addr_t[j], 32'h0);
            end
            i_request(32'h500);
        join
        drain();

        // Asynchronous reset while the arbiter waits on a slow memory.
        lat = 6;
        expect_txn(1'b0, 1'b0, 32'h600, 32'h0, 32'h0);
        void'(exp_rsp.pop_back());
        d_request(1'b0, 32'h600, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rv0 = rv_count;
        repeat (8) @(negedge clk);
        check("no_stray_rvalid", 32'(rv_count - rv0), 32'd0);
        check("reset_drain", 32'(exp_gnt.size() + exp_mem.size()), 32'd0);

        // Arbiter is back in IDLE and serves a fresh load.
        lat = 1;
        mem_arr[32'h600] = 32'h6060_6060;
        expect_txn(1'b0, 1'b0, 32'h600, 32'h0, 32'h6060_6060);
        d_request(1'b0, 32'h600, 32'h0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
